// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequenced shift-and-add multiplier.
// The block processes one multiplier bit per clock. Operands arrive over a
// valid/ready input handshake. The unsigned 2*WIDTH-bit product leaves over
// a valid/ready output handshake. Input and output handshakes never overlap:
// a new operand pair is accepted only after the previous product is taken.
module mult_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]  count;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  acc_sum;
    logic           accept;
    logic           zero_mplier;
    logic           run_last;

    // Conditional partial-product add. a*b < 2^PW, so the sum never wraps.
    function automatic logic [PW-1:0] add_partial(input logic [PW-1:0] sum,
                                                  input logic [PW-1:0] addend,
                                                  input logic        en);
        add_partial = en ? (sum + addend) : sum;
    endfunction

    assign in_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign accept      = in_valid && in_ready;
    assign zero_mplier = EARLY_EXIT && (b == '0);
    assign acc_sum     = add_partial(acc, mcand, mplier[0]);
    assign run_last    = (count == LAST_BIT) ||
                         (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> run bit by bit -> hold result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = zero_mplier ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (run_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift/accumulate in RUN, and capture
    // the product only on entry to DONE so it stays put while out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        if (zero_mplier) begin
                            product <= '0;
                        end
                    end
                end
                S_RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (run_last) begin
                        product <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl (WIDTH=8). Two instances are used, one per
// EARLY_EXIT setting; `sel` steers the shared stimulus to one of them.
// Expected products go into a queue when operands are driven. They are
// popped and compared when a product is handshaken out.
module tb_mult_seq_ctrl;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          sel;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    logic          ir0, ov0, busy0, ir1, ov1, busy1;
    logic [2*W-1:0] prod0, prod1;
    logic          iv0, iv1, or0, or1;

    logic          in_ready, out_valid, busy;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    assign iv0 = in_valid & ~sel;
    assign iv1 = in_valid & sel;
    assign or0 = out_ready & ~sel;
    assign or1 = out_ready & sel;
    assign in_ready  = sel ? ir1 : ir0;
    assign out_valid = sel ? ov1 : ov0;
    assign busy      = sel ? busy1 : busy0;
    assign product   = sel ? prod1 : prod0;

    mult_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .out_valid(ov0), .out_ready(or0),
        .product(prod0), .busy(busy0)
    );

    mult_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(or1),
        .product(prod1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        ref_mul = {8'd0, x} * {8'd0, y};
    endfunction

    // Present operands at a negedge, hold until accepted, return at the negedge after accept.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, output bit ok);
        int n = 0;
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Wait for out_valid; lat = negedges after the accept-edge negedge (= RUN cycles).
    task automatic recv(output logic [2*W-1:0] p, output int lat, output bit ir_seen, output bit ok);
        int n = 0;
        ir_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) ir_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (in_ready) ir_seen = 1'b1;
        ok  = out_valid;
        lat = n;
        p   = product;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready0: got %0b expected 1", ir0); end
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid0: got %0b expected 0", ov0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0: got %0b expected 0", busy0); end
        checks++; if (prod0 !== 16'd0) begin failures++; $display("FAIL reset_product0: got %0d expected 0", prod0); end
        checks++; if (ir1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready1: got %0b expected 1", ir1); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1: got %0b expected 0", ov1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1: got %0b expected 0", busy1); end
        checks++; if (prod1 !== 16'd0) begin failures++; $display("FAIL reset_product1: got %0d expected 0", prod1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [2*W-1:0] p, e;
        int lat;
        bit irs, ok;
        sel = 1'b0;
        out_ready = 1'b1;
        sb.push_back(ref_mul(8'd3, 8'd5));
        send(8'd3, 8'd5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_accept: got timeout expected accept"); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        recv(p, lat, irs, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got no out_valid expected out_valid"); end
        checks++; if (p !== e) begin failures++; $display("FAIL basic_product: got %0d expected %0d", p, e); end
        checks++; if (lat !== W) begin failures++; $display("FAIL basic_latency: got %0d run cycles expected %0d", lat, W); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_1cyc: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back: got %0b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ta[3] = '{8'd255, 8'd0, 8'd100};
        logic [W-1:0] tv[3] = '{8'd255, 8'd200, 8'd200};
        logic [2*W-1:0] p, e;
        int lat;
        bit irs, ok;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ref_mul(ta[i], tv[i]));
            send(ta[i], tv[i], ok);
            recv(p, lat, irs, ok);
            e = sb.pop_front();
            checks++; if (p !== e) begin failures++; $display("FAIL b2b_product[%0d]: got %0d expected %0d", i, p, e); end
            checks++; if (lat !== W) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, W); end
            checks++; if (irs !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_low[%0d]: got %0b expected 0", i, irs); end
        end
    endtask

    task automatic test_stall;
        logic [2*W-1:0] p, e;
        int lat, n;
        bit irs, ok;
        sel = 1'b0;
        out_ready = 1'b0;
        sb.push_back(ref_mul(8'd123, 8'd45));
        send(8'd123, 8'd45, ok);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %0b expected 1", i, out_valid); end
            checks++; if (product !== e) begin failures++; $display("FAIL stall_product[%0d]: got %0d expected %0d", i, product, e); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, in_ready); end
            in_valid = 1'b1; a = 8'd7; b = 8'd7;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_idle: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_no_7x7: got %0b expected 0", out_valid); end
        checks++; if (product !== e) begin failures++; $display("FAIL stall_hold_idle: got %0d expected %0d", product, e); end
        sb.push_back(ref_mul(8'd7, 8'd7));
        send(8'd7, 8'd7, ok);
        recv(p, lat, irs, ok);
        e = sb.pop_front();
        checks++; if (p !== e) begin failures++; $display("FAIL stall_next_product: got %0d expected %0d", p, e); end
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] p, e;
        int lat;
        bit irs, ok;
        sel = 1'b0;
        send(8'd200, 8'd200, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %0b expected 0", out_valid); end
        checks++; if (product !== 16'd0) begin failures++; $display("FAIL rstmid_product: got %0d expected 0", product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back(ref_mul(8'd2, 8'd9));
        send(8'd2, 8'd9, ok);
        recv(p, lat, irs, ok);
        e = sb.pop_front();
        checks++; if (p !== e) begin failures++; $display("FAIL rstmid_product_after: got %0d expected %0d", p, e); end
        checks++; if (lat !== W) begin failures++; $display("FAIL rstmid_latency: got %0d expected %0d", lat, W); end
    endtask

    task automatic test_early_exit;
        logic [W-1:0] ta[3] = '{8'd77, 8'd99, 8'd2};
        logic [W-1:0] tv[3] = '{8'd1, 8'd0, 8'h80};
        int exp_lat[3] = '{1, 0, 8};
        logic [2*W-1:0] p, e;
        int lat;
        bit irs, ok;
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ref_mul(ta[i], tv[i]));
            send(ta[i], tv[i], ok);
            recv(p, lat, irs, ok);
            e = sb.pop_front();
            checks++; if (p !== e) begin failures++; $display("FAIL early_product[%0d]: got %0d expected %0d", i, p, e); end
            checks++; if (lat !== exp_lat[i]) begin failures++; $display("FAIL early_latency[%0d]: got %0d expected %0d", i, lat, exp_lat[i]); end
        end
    endtask

    task automatic test_random;
        localparam int N = 500;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            out_ready = 1'b0;
            @(negedge clk);
            fork
                begin
                    bit ok;
                    logic [W-1:0] ta, tv;
                    for (int i = 0; i < N; i++) begin
                        ta = 8'($urandom);
                        tv = 8'($urandom);
                        if ($urandom_range(0, 7) == 0) tv = 8'($urandom_range(0, 3));
                        sb.push_back(ref_mul(ta, tv));
                        send(ta, tv, ok);
                        if (!ok) begin
                            checks++; failures++;
                            $display("FAIL rand_accept_timeout[%0d]: got no accept expected accept", i);
                        end
                    end
                end
                begin
                    int got = 0;
                    int cyc = 0;
                    bit hv = 1'b0;
                    logic [2*W-1:0] held, e;
                    while (got < N && cyc < N * 60) begin
                        @(negedge clk);
                        cyc++;
                        out_ready = 1'($urandom_range(0, 1));
                        if (out_valid) begin
                            if (hv) begin
                                checks++;
                                if (product !== held) begin failures++; $display("FAIL rand_stable: got %0d expected %0d", product, held); end
                            end
                            held = product;
                            hv = 1'b1;
                            if (out_ready) begin
                                checks++;
                                if (sb.size() == 0) begin
                                    failures++;
                                    $display("FAIL rand_extra_result: got %0d expected none", product);
                                end else begin
                                    e = sb.pop_front();
                                    if (product !== e) begin failures++; $display("FAIL rand_product[%0d]: got %0d expected %0d", got, product, e); end
                                end
                                got++;
                                hv = 1'b0;
                            end
                        end
                    end
                    checks++;
                    if (got !== N) begin failures++; $display("FAIL rand_count: got %0d expected %0d", got, N); end
                end
            join
            @(negedge clk);
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (sb.size() !== 0) begin failures++; $display("FAIL rand_leftover: got %0d expected 0", sb.size()); end
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_early_exit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
